// File: rtl/gpu_sprite_engine.sv
// ---------------------------------------------------------------------------
// gpu_sprite_engine
//   VGA timing generator plus an N-channel sprite compositor behind a simple
//   word-addressed register bus. The bg, mask, ctrl and sprite registers are
//   written as shadow copies. They are copied to the active set on the last
//   pixel of each frame, so a frame is always drawn from one consistent set.
//
//   Optional feature macro: GPU_SPRITE_COLLISION_EN
//     defined   -> sticky per-sprite collision flags in status[16+N-1:16],
//                  cleared by writing 1 (W1C). A set in the same cycle as a
//                  clear wins.
//     undefined -> no collision logic; status[31:16] reads 0.
//
// Ports
//   aclk        in   pixel/bus clock
//   areset      in   asynchronous reset, active-high
//   wr_en       in   register write strobe (one cycle)
//   wr_addr     in   [ADDR_W-1:0] write word address
//   wr_data     in   [31:0] write data
//   rd_en       in   register read strobe
//   rd_addr     in   [ADDR_W-1:0] read word address
//   rd_data     out  [31:0] read data, valid 1 cycle after rd_en
//   pixel_send  out  [COLOR_W-1:0] composited pixel
//   h_sync      out  horizontal sync, active-low
//   v_sync      out  vertical sync, active-low
//   frame_start out  1-cycle pulse after the shadow->active copy edge
//
// Register map (word addresses)
//   0 bg colour | 1 sprite mask | 2 ctrl[0] display enable
//   3 status: [15:0] frame count, [16+N-1:16] collision (W1C)
//   4+2k sprite k: x[9:0] y[19:10] h[29:20]
//   5+2k sprite k: w[9:0] colour[16+COLOR_W-1:16]
// ---------------------------------------------------------------------------
module gpu_sprite_engine #(
  parameter int N_SPRITES = 4,
  parameter int COLOR_W   = 12,
  parameter int ADDR_W    = 6,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [31:0]        rd_data,
  output logic [COLOR_W-1:0] pixel_send,
  output logic               h_sync,
  output logic               v_sync,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters and coordinate sums share one 11-bit width so x+w never wraps.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Shadow (bus-visible) and active (display-visible) register sets
  logic [COLOR_W-1:0]   bg_sh_q, bg_act_q;
  logic [N_SPRITES-1:0] mask_sh_q, mask_act_q;
  logic                 ctrl_sh_q, ctrl_act_q;
  logic [9:0]           x_sh_q   [N_SPRITES];
  logic [9:0]           y_sh_q   [N_SPRITES];
  logic [9:0]           hgt_sh_q [N_SPRITES];
  logic [9:0]           wid_sh_q [N_SPRITES];
  logic [COLOR_W-1:0]   col_sh_q [N_SPRITES];
  logic [9:0]           x_act_q  [N_SPRITES];
  logic [9:0]           y_act_q  [N_SPRITES];
  logic [9:0]           hgt_act_q[N_SPRITES];
  logic [9:0]           wid_act_q[N_SPRITES];
  logic [COLOR_W-1:0]   col_act_q[N_SPRITES];

  logic [10:0]          h_cnt_q, v_cnt_q, h_cnt_d, v_cnt_d;
  logic [15:0]          frame_cnt_q;
  logic [31:0]          rd_data_q, rd_data_d;
  logic [COLOR_W-1:0]   pix_q, pix_d;
  logic                 hs_q, hs_d, vs_q, vs_d, fs_q;

  logic                 frame_end, in_active;
  logic [N_SPRITES-1:0] hit;
  logic [N_SPRITES-1:0] coll_bits;
  logic                 wr_bg, wr_mask, wr_ctrl;
  logic [N_SPRITES-1:0] wr_w0, wr_w1;

  // Top two data bits are never stored in any register.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data[31:30];

  assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign in_active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  // Hit test on the current counters. A zero width/height makes the
  // half-open range empty, so it never hits without a special case.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_SPRITES; k++) begin
      hit[k] = mask_act_q[k]
            && ({1'b0, x_act_q[k]} <= h_cnt_q)
            && (h_cnt_q < ({1'b0, x_act_q[k]} + {1'b0, wid_act_q[k]}))
            && ({1'b0, y_act_q[k]} <= v_cnt_q)
            && (v_cnt_q < ({1'b0, y_act_q[k]} + {1'b0, hgt_act_q[k]}));
    end
  end

  // Priority compositor: walk from the highest index down so the lowest
  // hitting index is the one left in pix_d.
  always_comb begin
    pix_d = '0;
    if (in_active && ctrl_act_q) begin
      pix_d = bg_act_q;
      for (int k = N_SPRITES - 1; k >= 0; k--) begin
        if (hit[k]) pix_d = col_act_q[k];
      end
    end
    hs_d = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vs_d = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
  end

  always_comb begin
    wr_bg   = wr_en && (wr_addr == ADDR_W'(0));
    wr_mask = wr_en && (wr_addr == ADDR_W'(1));
    wr_ctrl = wr_en && (wr_addr == ADDR_W'(2));
    wr_w0   = '0;
    wr_w1   = '0;
    for (int k = 0; k < N_SPRITES; k++) begin
      wr_w0[k] = wr_en && (wr_addr == ADDR_W'(4 + 2 * k));
      wr_w1[k] = wr_en && (wr_addr == ADDR_W'(5 + 2 * k));
    end
  end

  // Reads see the pre-edge shadow values, so a same-address write in the
  // same cycle is not visible until the next read.
  always_comb begin
    rd_data_d = '0;
    if (rd_addr == ADDR_W'(0)) rd_data_d[COLOR_W-1:0] = bg_sh_q;
    if (rd_addr == ADDR_W'(1)) rd_data_d[N_SPRITES-1:0] = mask_sh_q;
    if (rd_addr == ADDR_W'(2)) rd_data_d[0] = ctrl_sh_q;
    if (rd_addr == ADDR_W'(3)) begin
      rd_data_d[15:0]           = frame_cnt_q;
      rd_data_d[16+:N_SPRITES]  = coll_bits;
    end
    for (int k = 0; k < N_SPRITES; k++) begin
      if (rd_addr == ADDR_W'(4 + 2 * k))
        rd_data_d = {2'b00, hgt_sh_q[k], y_sh_q[k], x_sh_q[k]};
      if (rd_addr == ADDR_W'(5 + 2 * k)) begin
        rd_data_d[9:0]         = wid_sh_q[k];
        rd_data_d[16+:COLOR_W] = col_sh_q[k];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bg_sh_q     <= '0;
      bg_act_q    <= '0;
      mask_sh_q   <= '0;
      mask_act_q  <= '0;
      ctrl_sh_q   <= 1'b0;
      ctrl_act_q  <= 1'b0;
      for (int k = 0; k < N_SPRITES; k++) begin
        x_sh_q[k]    <= '0;
        y_sh_q[k]    <= '0;
        hgt_sh_q[k]  <= '0;
        wid_sh_q[k]  <= '0;
        col_sh_q[k]  <= '0;
        x_act_q[k]   <= '0;
        y_act_q[k]   <= '0;
        hgt_act_q[k] <= '0;
        wid_act_q[k] <= '0;
        col_act_q[k] <= '0;
      end
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      rd_data_q   <= '0;
      pix_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;

      // Copy reads the pre-edge shadows; a write on this same edge only
      // reaches the shadow and shows up one frame later.
      if (frame_end) begin
        bg_act_q    <= bg_sh_q;
        mask_act_q  <= mask_sh_q;
        ctrl_act_q  <= ctrl_sh_q;
        for (int k = 0; k < N_SPRITES; k++) begin
          x_act_q[k]   <= x_sh_q[k];
          y_act_q[k]   <= y_sh_q[k];
          hgt_act_q[k] <= hgt_sh_q[k];
          wid_act_q[k] <= wid_sh_q[k];
          col_act_q[k] <= col_sh_q[k];
        end
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end

      if (wr_bg)   bg_sh_q   <= wr_data[COLOR_W-1:0];
      if (wr_mask) mask_sh_q <= wr_data[N_SPRITES-1:0];
      if (wr_ctrl) ctrl_sh_q <= wr_data[0];
      for (int k = 0; k < N_SPRITES; k++) begin
        if (wr_w0[k]) begin
          x_sh_q[k]   <= wr_data[9:0];
          y_sh_q[k]   <= wr_data[19:10];
          hgt_sh_q[k] <= wr_data[29:20];
        end
        if (wr_w1[k]) begin
          wid_sh_q[k] <= wr_data[9:0];
          col_sh_q[k] <= wr_data[16+:COLOR_W];
        end
      end

      if (rd_en) rd_data_q <= rd_data_d;

      // Output stage: pixel and syncs registered together one cycle after
      // the counters.
      pix_q <= pix_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= frame_end;
    end
  end

`ifdef GPU_SPRITE_COLLISION_EN
  logic [N_SPRITES-1:0] coll_q, coll_set, coll_clr, others;

  always_comb begin
    coll_set = '0;
    others   = '0;
    for (int k = 0; k < N_SPRITES; k++) begin
      others    = hit;
      others[k] = 1'b0;
      coll_set[k] = in_active && hit[k] && (|others);
    end
    coll_clr = (wr_en && (wr_addr == ADDR_W'(3))) ? wr_data[16+:N_SPRITES] : '0;
  end

  // Clear first, then OR in new sets so a simultaneous set survives.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) coll_q <= '0;
    else        coll_q <= (coll_q & ~coll_clr) | coll_set;
  end

  assign coll_bits = coll_q;
`else
  assign coll_bits = '0;
`endif

  assign rd_data     = rd_data_q;
  assign pixel_send  = pix_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_gpu_sprite_engine.sv
module tb_gpu_sprite_engine;

  localparam int N   = 4;
  localparam int CW  = 12;
  localparam int AW  = 4;
  localparam int HA  = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA  = 20, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FR  = HT * VT;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic [CW-1:0] pixel_send;
  logic          h_sync, v_sync, frame_start;

  always #5 clk = ~clk;

  gpu_sprite_engine #(
    .N_SPRITES(N), .COLOR_W(CW), .ADDR_W(AW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .aclk(clk), .areset(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pixel_send(pixel_send), .h_sync(h_sync), .v_sync(v_sync),
    .frame_start(frame_start)
  );

  typedef struct {
    logic [CW-1:0] pix;
    logic          hs;
    logic          vs;
    logic          fs;
    bit            rd_chk;
    logic [31:0]   rd_val;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  int   first_fall = -1;

  // Reference model: register contents as plain integers, screen position
  // as (mh, mv), everything updated once per modelled clock edge.
  int sh_bg, sh_mask, sh_ctrl, act_bg, act_mask, act_ctrl;
  int sh_x[N], sh_y[N], sh_h[N], sh_w[N], sh_c[N];
  int ac_x[N], ac_y[N], ac_h[N], ac_w[N], ac_c[N];
  int mh, mv, mframe, mcoll;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    sh_bg = 0; sh_mask = 0; sh_ctrl = 0; act_bg = 0; act_mask = 0; act_ctrl = 0;
    for (int k = 0; k < N; k++) begin
      sh_x[k] = 0; sh_y[k] = 0; sh_h[k] = 0; sh_w[k] = 0; sh_c[k] = 0;
      ac_x[k] = 0; ac_y[k] = 0; ac_h[k] = 0; ac_w[k] = 0; ac_c[k] = 0;
    end
    mh = 0; mv = 0; mframe = 0; mcoll = 0;
  endfunction

  function automatic bit mhit(int k, int h, int v);
    return ((act_mask >> k) & 1) == 1 &&
           h >= ac_x[k] && h < ac_x[k] + ac_w[k] &&
           v >= ac_y[k] && v < ac_y[k] + ac_h[k];
  endfunction

  function automatic logic [CW-1:0] mpix(int h, int v);
    if (!(h < HA && v < VA && act_ctrl == 1)) return '0;
    for (int k = 0; k < N; k++)
      if (mhit(k, h, v)) return CW'(ac_c[k]);
    return CW'(act_bg);
  endfunction

  function automatic logic [31:0] mread(int a);
    int r;
    r = 0;
    if (a == 0) r = sh_bg;
    else if (a == 1) r = sh_mask;
    else if (a == 2) r = sh_ctrl;
    else if (a == 3) r = (mcoll << 16) | mframe;
    else if (a >= 4 && a < 4 + 2 * N) begin
      if (a % 2 == 0) r = sh_x[(a-4)/2] | (sh_y[(a-4)/2] << 10) | (sh_h[(a-4)/2] << 20);
      else            r = sh_w[(a-4)/2] | (sh_c[(a-4)/2] << 16);
    end
    return 32'(r);
  endfunction

  function automatic void mwrite(int a, logic [31:0] d);
    if (a == 0) sh_bg = int'(d[CW-1:0]);
    else if (a == 1) sh_mask = int'(d[N-1:0]);
    else if (a == 2) sh_ctrl = int'(d[0]);
    else if (a >= 4 && a < 4 + 2 * N) begin
      if (a % 2 == 0) begin
        sh_x[(a-4)/2] = int'(d[9:0]);
        sh_y[(a-4)/2] = int'(d[19:10]);
        sh_h[(a-4)/2] = int'(d[29:20]);
      end else begin
        sh_w[(a-4)/2] = int'(d[9:0]);
        sh_c[(a-4)/2] = int'(d[16+:CW]);
      end
    end
  endfunction

  // Drive one cycle's inputs (called just after a falling edge) and record
  // what the DUT must show after the following rising edge.
  task automatic body(input bit we, input int wa, input logic [31:0] wd,
                      input bit re, input int ra);
    exp_t e;
    int   nhit, setm, clr;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    rd_en = re; rd_addr = AW'(ra);
    e.pix    = mpix(mh, mv);
    e.hs     = !(mh >= HA + HFP && mh < HA + HFP + HSY);
    e.vs     = !(mv >= VA + VFP && mv < VA + VFP + VSY);
    e.fs     = (mh == HT - 1 && mv == VT - 1);
    e.rd_chk = re;
    e.rd_val = re ? mread(ra) : 32'h0;
    q.push_back(e);
`ifdef GPU_SPRITE_COLLISION_EN
    nhit = 0; setm = 0;
    if (mh < HA && mv < VA)
      for (int k = 0; k < N; k++)
        if (mhit(k, mh, mv)) begin nhit++; setm |= (1 << k); end
    if (nhit < 2) setm = 0;
    clr = (we && wa == 3) ? int'(wd[16+:N]) : 0;
    mcoll = (mcoll & ~clr) | setm;
`else
    nhit = 0; setm = 0; clr = 0;
`endif
    if (e.fs) begin
      act_bg = sh_bg; act_mask = sh_mask; act_ctrl = sh_ctrl;
      for (int k = 0; k < N; k++) begin
        ac_x[k] = sh_x[k]; ac_y[k] = sh_y[k]; ac_h[k] = sh_h[k];
        ac_w[k] = sh_w[k]; ac_c[k] = sh_c[k];
      end
      mframe = (mframe + 1) % 65536;
    end
    if (we) mwrite(wa, wd);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
  endtask

  task automatic step(input bit we, input int wa, input logic [31:0] wd,
                      input bit re, input int ra);
    @(negedge clk);
    body(we, wa, wd, re, ra);
  endtask

  task automatic run(input int n);
    repeat (n) step(0, 0, 32'h0, 0, 0);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    step(1, a, d, 0, 0);
  endtask

  task automatic rd(input int a);
    step(0, 0, 32'h0, 1, a);
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < 2 * FR) begin
      run(1);
      n++;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    pops = 0;
    first_fall = -1;
    body(0, 0, 32'h0, 0, 0);
  endtask

  function automatic logic [31:0] spr0(int x, int y, int h);
    return 32'(x | (y << 10) | (h << 20));
  endfunction

  function automatic logic [31:0] spr1(int w, int c);
    return 32'(w | (c << 16));
  endfunction

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      pops++;
      if (first_fall < 0 && h_sync == 1'b0) first_fall = pops;
      chk("pixel", 32'(pixel_send), 32'(mon_e.pix));
      chk("h_sync", 32'(h_sync), 32'(mon_e.hs));
      chk("v_sync", 32'(v_sync), 32'(mon_e.vs));
      chk("frame_start", 32'(frame_start), 32'(mon_e.fs));
      if (mon_e.rd_chk) chk("rd_data", rd_data, mon_e.rd_val);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, a;
    logic [31:0] d;
    rst = 1'b1; wr_en = 0; rd_en = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pixel", 32'(pixel_send), 32'h0);
    chk("rst_h_sync", 32'(h_sync), 32'h1);
    chk("rst_v_sync", 32'(v_sync), 32'h1);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);

    // Two idle frames: sync shapes checked every cycle, then frame count.
    release_rst();
    run(2 * FR - 1);
    chk("first_hsync_fall", 32'(first_fall), 32'(HA + HFP + 1));
    rd(3);
    @(posedge clk); #2;
    chk("frame_cnt_after_2", {16'h0, rd_data[15:0]}, 32'd2);

    // Background only.
    wr(0, 32'hABC);
    wr(2, 32'h1);
    rd(0);
    run_to(0, 0);
    run(FR);

    // One sprite written mid-frame; that frame still shows bg.
    run(100);
    wr(4, spr0(5, 4, 6));
    wr(5, spr1(7, 'h00F));
    wr(1, 32'h1);
    rd(4); rd(5); rd(1);
    run_to(0, 0);
    run(FR);

    // Overlap: lower index wins; collision flags and W1C.
    wr(5, spr1(7, 'hF00));
    wr(6, spr0(8, 6, 6));
    wr(7, spr1(7, 'h0F0));
    wr(1, 32'h3);
    run_to(0, 0);
    run(FR);
    rd(3);
    wr(3, 32'h0003_0000);
    rd(3);
    run_to(0, 0);
    run(FR);
    rd(3);

    // Clipping at the right edge, far-right wrap candidate, zero width.
    wr(8, spr0(36, 0, 20));
    wr(9, spr1(10, 'hAAA));
    wr(10, spr0(0, 0, 20));
    wr(11, spr1(0, 'h555));
    wr(1, 32'hF);
    run_to(0, 0);
    run(FR);
    wr(8, spr0(50, 2, 10));
    wr(9, spr1(10, 'h123));
    run_to(0, 0);
    run(FR);

    // Randomised traffic, including unmapped addresses and same-address
    // read/write collisions.
    for (int i = 0; i < 8 * FR; i++) begin
      r = int'($urandom_range(99));
      a = int'($urandom_range(15));
      d = $urandom;
      if (a >= 4 && a % 2 == 0 && $urandom_range(3) != 0)
        d = spr0(int'($urandom_range(60)), int'($urandom_range(30)), int'($urandom_range(25)));
      else if (a >= 4 && $urandom_range(3) != 0)
        d = spr1(int'($urandom_range(30)), int'($urandom_range(4095)));
      else if (a == 2)
        d = 32'($urandom_range(3) != 0);
      if (r < 3)       step(1, a, d, ($urandom_range(1) == 1), a);
      else if (r < 13) rd(a);
      else             run(1);
    end

    // Asynchronous reset mid-line with sprites active.
    wr(4, spr0(5, 4, 6));
    wr(5, spr1(30, 'h0FF));
    wr(1, 32'h1);
    wr(2, 32'h1);
    run_to(0, 0);
    run_to(10, 5);
    @(negedge clk);
    wr_en = 0; rd_en = 0;
    #2 rst = 1'b1;
    #1;
    chk("amid_pixel", 32'(pixel_send), 32'h0);
    chk("amid_h_sync", 32'(h_sync), 32'h1);
    chk("amid_v_sync", 32'(v_sync), 32'h1);
    chk("amid_frame_start", 32'(frame_start), 32'h0);
    chk("amid_rd_data", rd_data, 32'h0);
    model_reset();
    @(negedge clk);
    release_rst();
    run(FR - 1);
    chk("post_rst_hsync_fall", 32'(first_fall), 32'(HA + HFP + 1));
    rd(3);
    @(posedge clk); #2;
    chk("post_rst_frame_cnt", {16'h0, rd_data[15:0]}, 32'd1);

    @(negedge clk);
    wr_en = 0; rd_en = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
